// File: rtl/serv_csr_xfer.sv
// serv_csr_xfer: moves one 32-bit CSR word between a host port and the
// bit-serial CSR datapath of a SERV core, stalling the core while shifting.
// Optional build macro SERV_CSR_XFER_TIMEOUT_EN adds a bounded wait for core
// idle; without it the wait is unbounded and o_host_err is tied to 0.
module serv_csr_xfer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_host_req,
   input  logic        i_host_we,
   input  logic [1:0]  i_host_sel,
   input  logic [31:0] i_host_wdata,
   output logic        o_host_ack,
   output logic [31:0] o_host_rdata,
   output logic        o_host_err,
   input  logic        i_core_idle,
   output logic        o_core_stall,
   output logic        o_csr_en,
   output logic [1:0]  o_csr_sel,
   output logic [4:0]  o_csr_cnt,
   output logic        o_csr_wen,
   output logic        o_csr_wdat,
   input  logic        i_csr_rdat
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state;
   logic           we_q;
   logic [DW-1:0]  wr_q;
   logic [DW-1:0]  rd_q;

`ifdef SERV_CSR_XFER_TIMEOUT_EN
   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WAIT_W-1:0] wait_cnt;
`else
   // The wait is unbounded in this build, so the error flag never rises.
   assign o_host_err = 1'b0;

   // TIMEOUT_CYCLES only shapes the timeout build; this empty block keeps it referenced.
   if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
   end
`endif

   // Transfer sequencer: all outputs and datapath registers update here.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         we_q         <= 1'b0;
         wr_q         <= '0;
         rd_q         <= '0;
         o_host_ack   <= 1'b0;
         o_host_rdata <= '0;
         o_core_stall <= 1'b0;
         o_csr_en     <= 1'b0;
         o_csr_sel    <= '0;
         o_csr_cnt    <= '0;
         o_csr_wen    <= 1'b0;
         o_csr_wdat   <= 1'b0;
`ifdef SERV_CSR_XFER_TIMEOUT_EN
         wait_cnt     <= '0;
         o_host_err   <= 1'b0;
`endif
      end else begin
         o_host_ack <= 1'b0;
`ifdef SERV_CSR_XFER_TIMEOUT_EN
         o_host_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (i_host_req) begin
                  we_q      <= i_host_we;
                  o_csr_sel <= i_host_sel;
                  if (i_core_idle) begin
                     // Bit 0 goes out with cnt 0, the rest waits in the shifter.
                     state        <= S_SHIFT;
                     o_csr_en     <= 1'b1;
                     o_core_stall <= 1'b1;
                     o_csr_wen    <= i_host_we;
                     o_csr_wdat   <= i_host_wdata[0];
                     wr_q         <= {1'b0, i_host_wdata[DW-1:1]};
                  end else begin
                     state <= S_WAIT;
                     wr_q  <= i_host_wdata;
                  end
               end
            end

            S_WAIT: begin
               if (i_core_idle) begin
                  state        <= S_SHIFT;
                  o_csr_en     <= 1'b1;
                  o_core_stall <= 1'b1;
                  o_csr_wen    <= we_q;
                  o_csr_wdat   <= wr_q[0];
                  wr_q         <= {1'b0, wr_q[DW-1:1]};
`ifdef SERV_CSR_XFER_TIMEOUT_EN
                  wait_cnt     <= '0;
`endif
               end
`ifdef SERV_CSR_XFER_TIMEOUT_EN
               else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Give up without touching the CSR datapath.
                  state        <= S_DONE;
                  o_host_ack   <= 1'b1;
                  o_host_err   <= 1'b1;
                  o_host_rdata <= '0;
                  o_core_stall <= 1'b1;
                  wait_cnt     <= '0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
`endif
            end

            S_SHIFT: begin
               // Read bits arrive LSB first and enter at the top.
               rd_q      <= {i_csr_rdat, rd_q[DW-1:1]};
               o_csr_cnt <= o_csr_cnt + CW'(1);
               if (o_csr_cnt == CW'(DW - 1)) begin
                  state        <= S_DONE;
                  o_csr_en     <= 1'b0;
                  o_csr_wen    <= 1'b0;
                  o_csr_wdat   <= 1'b0;
                  o_host_ack   <= 1'b1;
                  o_host_rdata <= {i_csr_rdat, rd_q[DW-1:1]};
               end else begin
                  o_csr_wdat <= wr_q[0];
                  wr_q       <= {1'b0, wr_q[DW-1:1]};
               end
            end

            S_DONE: begin
               state        <= S_IDLE;
               o_core_stall <= 1'b0;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/serv_csr_xfer.md
SERV_CSR_XFER -- requirements
Module: serv_csr_xfer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for core idle (used only with SERV_CSR_XFER_TIMEOUT_EN).
REQ-002 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_host_req  input  1  host requests one 32-bit CSR transfer; held high until o_host_ack.
REQ-005 i_host_we  input  1  1 = write i_host_wdata into CSR; 0 = read only.
REQ-006 i_host_sel  input  2  CSR select: 00 mstatus, 01 mie, 10 mcause, 11 mtvec.
REQ-007 i_host_wdata  input  32  write word; sampled at request acceptance.
REQ-008 o_host_ack  output  1  one-cycle transfer-complete pulse.
REQ-009 o_host_rdata  output  32  word read from CSR; valid from o_host_ack until next acceptance.
REQ-010 o_host_err  output  1  timeout flag, valid with o_host_ack.
REQ-011 i_core_idle  input  1  core is between instructions and will not access CSRs this cycle.
REQ-012 o_core_stall  output  1  holds core off the CSR datapath.
REQ-013 o_csr_en  output  1  serial CSR access active.
REQ-014 o_csr_sel  output  2  registered copy of i_host_sel during access.
REQ-015 o_csr_cnt  output  5  bit index of current serial cycle, 0..31.
REQ-016 o_csr_wen  output  1  serial write enable.
REQ-017 o_csr_wdat  output  1  serial write bit, LSB first.
REQ-018 i_csr_rdat  input  1  serial read bit from CSR, LSB first, same cycle as o_csr_cnt.

Function
REQ-019 The block SHALL implement states IDLE, WAIT, SHIFT, DONE.
REQ-020 IDLE: when i_host_req=1, latch i_host_we, i_host_sel and i_host_wdata; go to SHIFT if i_core_idle=1, else WAIT.
REQ-021 WAIT: go to SHIFT in the cycle after i_core_idle=1 is sampled; o_core_stall SHALL stay 0 in WAIT.
REQ-022 SHIFT: o_csr_en=1 and o_core_stall=1 for exactly 32 cycles, with o_csr_cnt counting 0 to 31 from cycle 1 onward; then go to DONE.
REQ-023 SHIFT: o_csr_wdat SHALL be bit o_csr_cnt of the latched write word, supplied through a right-shifting register; o_csr_wen equals the latched we.
REQ-024 SHIFT: i_csr_rdat SHALL be shifted into bit 31 of a right-shifting read register each cycle, so that after cnt 31 the register holds the CSR word.
REQ-025 DONE: o_host_ack=1 and o_core_stall=1 for one cycle; o_host_rdata presents the read register; then go to IDLE.
REQ-026 Latency: with request accepted and i_core_idle=1 in cycle N, SHIFT occupies N+1..N+32 and ack is in N+33.
REQ-027 A new request SHALL be accepted only in IDLE, so back-to-back transfers start at least 34 cycles apart.
REQ-028 Deassertion of i_host_req after acceptance SHALL NOT abort a transfer, and ack SHALL still be issued.
REQ-029 i_core_idle changes during SHIFT/DONE SHALL be ignored.
REQ-030 The o_csr_cnt counter SHALL wrap 31 to 0 exactly once at the end of SHIFT and SHALL read 0 outside SHIFT.
REQ-031 o_csr_en, o_csr_wen and o_csr_wdat SHALL be 0 outside SHIFT.

Reset
REQ-032 i_rst_n=0 SHALL immediately force IDLE, and every output and internal register SHALL be 0.
REQ-033 Reset mid-SHIFT SHALL abort with no ack, and the first cycle after release is IDLE.

Configuration
REQ-034 With SERV_CSR_XFER_TIMEOUT_EN defined, a WAIT-cycle counter SHALL be present. After TIMEOUT_CYCLES WAIT cycles without i_core_idle, the block goes to DONE with o_host_err=1 and o_host_rdata=0, skipping SHIFT.
REQ-035 With SERV_CSR_XFER_TIMEOUT_EN undefined, WAIT SHALL last indefinitely and o_host_err SHALL be constant 0.

Verification
REQ-036 Read mcause, idle=1, CSR bits 0x8000_0007 LSB first -> ack 33 cycles after acceptance, rdata=0x8000_0007, wen=0 throughout.
REQ-037 Write mtvec 0x0000_1234 -> wen=1 for 32 cycles, wdat sequence equals bits of 0x1234 LSB first, cnt 0..31.
REQ-038 idle=0 for 10 cycles after request, then 1 -> stall=0 during wait, SHIFT starts the next cycle, ack 43 cycles after acceptance.
REQ-039 req dropped at cnt 5 -> transfer completes, single ack; req held high after ack -> next accept only after IDLE, 34-cycle spacing.
REQ-040 rst_n low at cnt 17 -> all outputs 0 at once, no ack, IDLE after release.
REQ-041 TIMEOUT_EN, TIMEOUT_CYCLES=4, idle=0 -> ack after 4 WAIT cycles with err=1, rdata=0, csr_en never set.
